commit_trace_buf: RTL and testbench

COMMIT_TRACE_BUF -- requirements
Module: commit_trace_buf

---
 rtl/commit_trace_buf.sv | 169 ++++++++++++++++
 tb/tb_commit_trace_buf.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buf.sv
// Commit trace buffer: records retired register writes as {pc, rd, data} entries, either as a
// streaming FIFO or as a trigger-centred ring capture around a matching PC.
module commit_trace_buf #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 4,
  parameter int unsigned SKIP_X0   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       commit_valid,
  input  logic [XLEN-1:0]            commit_pc,
  input  logic [4:0]                 commit_rd,
  input  logic [XLEN-1:0]            commit_data,
  input  logic                       mode,
  input  logic                       arm,
  input  logic [XLEN-1:0]            trig_pc,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [XLEN-1:0]            rd_pc,
  output logic [XLEN-1:0]            rd_data,
  output logic [4:0]                 rd_rd,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic [15:0]                drop_cnt,
  output logic [1:0]                 trig_state
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = (POST_TRIG > 0) ? $clog2(POST_TRIG + 1) : 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StPost  = 2'd2,
    StDone  = 2'd3
  } trig_state_e;

  trig_state_e   state_q, state_d;
  logic [PW-1:0] post_q, post_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   drop_q, drop_d;
  logic          mode_q;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];
  logic [4:0]      rd_mem   [DEPTH];

  logic eligible, pop, do_wr, flush, overwrite;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign rd_valid   = !empty;
  assign count      = count_q;
  assign drop_cnt   = drop_q;
  assign trig_state = state_q;
  assign rd_pc      = pc_mem[rd_ptr_q];
  assign rd_data    = data_mem[rd_ptr_q];
  assign rd_rd      = rd_mem[rd_ptr_q];

  always_comb begin
    eligible = commit_valid && ((SKIP_X0 == 0) || (commit_rd != 5'd0));
    pop      = !empty && rd_ready;
    do_wr    = 1'b0;
    flush    = 1'b0;
    state_d  = state_q;
    post_d   = post_q;
    drop_d   = drop_q;

    if (mode != mode_q) begin
      // Mode switch wins over everything, including a same-cycle commit.
      flush   = 1'b1;
      state_d = StIdle;
      post_d  = '0;
    end else if (!mode) begin
      state_d = StIdle;
      post_d  = '0;
      if (eligible) begin
        if (!full || pop) begin
          do_wr = 1'b1;
        end else if (drop_q != 16'hFFFF) begin
          drop_d = drop_q + 16'd1;
        end
      end
    end else if (arm) begin
      flush   = 1'b1;
      state_d = StArmed;
      post_d  = '0;
    end else begin
      case (state_q)
        StArmed: begin
          if (eligible) begin
            do_wr = 1'b1;
            if (commit_pc == trig_pc) begin
              if (POST_TRIG == 0) begin
                state_d = StDone;
              end else begin
                state_d = StPost;
                post_d  = PW'(POST_TRIG);
              end
            end
          end
        end
        StPost: begin
          if (eligible) begin
            do_wr  = 1'b1;
            post_d = post_q - PW'(1);
            if (post_q == PW'(1)) state_d = StDone;
          end
        end
        default: ;
      endcase
    end

    // Trigger capture keeps the newest DEPTH entries by pushing the head forward.
    overwrite = do_wr && full && !pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop || overwrite) rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_wr && !pop && !overwrite) begin
        count_d = count_q + CW'(1);
      end else if (pop && !do_wr) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      post_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      post_q   <= post_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      mode_q   <= mode;
    end
  end

  // Entry storage carries no reset; validity is tracked by count/pointers alone.
  always_ff @(posedge clk) begin
    if (do_wr && !flush) begin
      pc_mem[wr_ptr_q]   <= commit_pc;
      data_mem[wr_ptr_q] <= commit_data;
      rd_mem[wr_ptr_q]   <= commit_rd;
    end
  end

endmodule

// File: tb/tb_commit_trace_buf.sv
// Directed scoreboard bench for commit_trace_buf (DEPTH=4, POST_TRIG=2, SKIP_X0=1).
module tb_commit_trace_buf;

  localparam int unsigned XLEN = 32;
  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic [4:0]      commit_rd;
  logic [XLEN-1:0] commit_data;
  logic            mode;
  logic            arm;
  logic [XLEN-1:0] trig_pc;
  logic            rd_ready;
  logic            rd_valid;
  logic [XLEN-1:0] rd_pc;
  logic [XLEN-1:0] rd_data;
  logic [4:0]      rd_rd;
  logic [2:0]      count;
  logic            full;
  logic            empty;
  logic [15:0]     drop_cnt;
  logic [1:0]      trig_state;

  commit_trace_buf #(
    .XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(2), .SKIP_X0(1)
  ) dut (
    .clk(clk), .reset(reset), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_rd(commit_rd), .commit_data(commit_data), .mode(mode), .arm(arm),
    .trig_pc(trig_pc), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc),
    .rd_data(rd_data), .rd_rd(rd_rd), .count(count), .full(full), .empty(empty),
    .drop_cnt(drop_cnt), .trig_state(trig_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] dat(input logic [31:0] pc, input logic [4:0] rd);
    return pc ^ {rd, 27'h5A5A5A5};
  endfunction

  function automatic ent_t mk(input logic [31:0] pc, input logic [4:0] rd);
    ent_t e;
    e.pc = pc;
    e.rd = rd;
    e.data = dat(pc, rd);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [31:0] pc, input logic [4:0] rd);
    commit_valid = 1'b1;
    commit_pc    = pc;
    commit_rd    = rd;
    commit_data  = dat(pc, rd);
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic ring_push(input ent_t e);
    sb.push_back(e);
    if (sb.size() > DEPTH) sb.delete(0);
  endtask

  task automatic pop_check(input string tag);
    ent_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
    check({tag, "_pc"}, rd_pc, e.pc);
    check({tag, "_rd"}, {27'd0, rd_rd}, {27'd0, e.rd});
    check({tag, "_data"}, rd_data, e.data);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ent_t e;
    reset = 1'b0; commit_valid = 1'b0; commit_pc = '0; commit_rd = '0; commit_data = '0;
    mode = 1'b0; arm = 1'b0; trig_pc = '0; rd_ready = 1'b0;
    #12;
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_drop", {16'd0, drop_cnt}, 32'd0);
    check("rst_state", {30'd0, trig_state}, 32'd0);
    reset = 1'b1;
    tick();

    // Stream overflow: 6 commits into 4 slots
    for (int i = 1; i <= 6; i++) begin
      commit(32'h100 + 32'(4 * i), 5'(i));
      if (i <= 4) sb.push_back(mk(32'h100 + 32'(4 * i), 5'(i)));
    end
    check("ovf_count", {29'd0, count}, 32'd4);
    check("ovf_full", {31'd0, full}, 32'd1);
    check("ovf_drop", {16'd0, drop_cnt}, 32'd2);
    for (int i = 0; i < 4; i++) pop_check("drain1");
    check("drain1_empty", {31'd0, empty}, 32'd1);

    // Full with same-cycle commit and pop
    for (int i = 1; i <= 4; i++) begin
      commit(32'h200 + 32'(4 * i), 5'(i));
      sb.push_back(mk(32'h200 + 32'(4 * i), 5'(i)));
    end
    e = sb.pop_front();
    check("sim_head_rd", {27'd0, rd_rd}, {27'd0, e.rd});
    check("sim_head_pc", rd_pc, e.pc);
    sb.push_back(mk(32'h300, 5'd7));
    rd_ready = 1'b1;
    commit(32'h300, 5'd7);
    rd_ready = 1'b0;
    check("sim_count", {29'd0, count}, 32'd4);
    check("sim_drop", {16'd0, drop_cnt}, 32'd2);
    for (int i = 0; i < 4; i++) pop_check("drain2");

    // x0 commits are not eligible, even when full
    commit(32'h400, 5'd0);
    check("x0_count_empty", {29'd0, count}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      commit(32'h500 + 32'(4 * i), 5'(i));
      sb.push_back(mk(32'h500 + 32'(4 * i), 5'(i)));
    end
    commit(32'h400, 5'd0);
    check("x0_count_full", {29'd0, count}, 32'd4);
    check("x0_drop", {16'd0, drop_cnt}, 32'd2);
    for (int i = 0; i < 4; i++) pop_check("drain3");
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("pop_empty_count", {29'd0, count}, 32'd0);

    // Trigger capture around PC 0x10
    mode = 1'b1;
    tick();
    check("trg_idle", {30'd0, trig_state}, 32'd0);
    commit(32'h50, 5'd3);
    check("trg_idle_ignore", {29'd0, count}, 32'd0);
    trig_pc = 32'h10;
    pulse_arm();
    check("trg_armed", {30'd0, trig_state}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      commit(32'(4 * i), 5'(i + 1));
      if (i < 7) ring_push(mk(32'(4 * i), 5'(i + 1)));
      if (i == 4) check("trg_post_at_10", {30'd0, trig_state}, 32'd2);
      if (i == 5) check("trg_post_at_14", {30'd0, trig_state}, 32'd2);
      if (i == 6) check("trg_done_at_18", {30'd0, trig_state}, 32'd3);
    end
    check("trg_count", {29'd0, count}, 32'd4);
    check("trg_drop", {16'd0, drop_cnt}, 32'd2);
    for (int i = 0; i < 4; i++) pop_check("trg_drain");
    check("trg_done_hold", {30'd0, trig_state}, 32'd3);

    // Re-arm during POST restarts the capture
    trig_pc = 32'h48;
    pulse_arm();
    commit(32'h40, 5'd1);
    commit(32'h44, 5'd2);
    commit(32'h48, 5'd3);
    check("rearm_post", {30'd0, trig_state}, 32'd2);
    check("rearm_pre_count", {29'd0, count}, 32'd3);
    pulse_arm();
    check("rearm_state", {30'd0, trig_state}, 32'd1);
    check("rearm_flush", {29'd0, count}, 32'd0);
    check("rearm_empty", {31'd0, empty}, 32'd1);
    commit(32'h60, 5'd4); ring_push(mk(32'h60, 5'd4));
    commit(32'h48, 5'd5); ring_push(mk(32'h48, 5'd5));
    commit(32'h70, 5'd6); ring_push(mk(32'h70, 5'd6));
    commit(32'h74, 5'd7); ring_push(mk(32'h74, 5'd7));
    check("rearm_done", {30'd0, trig_state}, 32'd3);
    commit(32'h78, 5'd8);
    check("rearm_done_ignore", {29'd0, count}, 32'd4);
    for (int i = 0; i < 4; i++) pop_check("rearm_drain");

    // Asynchronous reset mid-capture
    trig_pc = 32'h84;
    pulse_arm();
    commit(32'h80, 5'd1);
    commit(32'h84, 5'd2);
    commit(32'h88, 5'd3);
    check("ar_pre_count", {29'd0, count}, 32'd3);
    check("ar_pre_state", {30'd0, trig_state}, 32'd2);
    #2 reset = 1'b0;
    #1;
    check("ar_count", {29'd0, count}, 32'd0);
    check("ar_empty", {31'd0, empty}, 32'd1);
    check("ar_state", {30'd0, trig_state}, 32'd0);
    check("ar_valid", {31'd0, rd_valid}, 32'd0);
    check("ar_drop", {16'd0, drop_cnt}, 32'd0);
    #2 reset = 1'b1;
    sb.delete();
    tick();
    check("ar_after_state", {30'd0, trig_state}, 32'd0);

    // Mode change flushes and drops the same-cycle commit
    pulse_arm();
    commit(32'h90, 5'd1);
    check("mc_pre_count", {29'd0, count}, 32'd1);
    mode = 1'b0;
    commit(32'h94, 5'd2);
    check("mc_count", {29'd0, count}, 32'd0);
    check("mc_state", {30'd0, trig_state}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
